// File: rtl/mcont_to_chnbuf_demux.sv
// Registers the memory-controller buffer write stream once and fans it out to NUM_CHN
// channel buffers, with per-sequence word counting and sticky channel/overflow errors.
module mcont_to_chnbuf_demux #(
    parameter int              NUM_CHN    = 16,
    parameter int              CHN_WIDTH  = 4,
    parameter int              ADDR_WIDTH = 7,
    parameter int              DATA_WIDTH = 64,
    parameter int              CNT_WIDTH  = 8,
    parameter logic [15:0]     CHN_MASK   = 16'hffff
) (
    input  logic                  rst,
    input  logic                  clk,
    input  logic                  ext_buf_wr,
    input  logic [ADDR_WIDTH-1:0] ext_buf_waddr,
    input  logic [CHN_WIDTH-1:0]  ext_buf_wchn,
    input  logic [DATA_WIDTH-1:0] ext_buf_wdata,
    input  logic                  seq_done,
    input  logic                  err_clr,
    output logic [NUM_CHN-1:0]    buf_wr,
    output logic [ADDR_WIDTH-1:0] buf_waddr,
    output logic [DATA_WIDTH-1:0] buf_wdata,
    output logic [NUM_CHN-1:0]    buf_done,
    output logic [CNT_WIDTH-1:0]  buf_nwords,
    output logic                  err_bad_chn,
    output logic                  err_ovf
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    function automatic logic [CNT_WIDTH-1:0] cnt_sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                         input logic inc);
        if (inc && (c != CNT_MAX))
            return c + 1'b1;
        return c;
    endfunction

    function automatic logic cnt_would_ovf(input logic [CNT_WIDTH-1:0] c, input logic inc);
        return inc && (c == CNT_MAX);
    endfunction

    logic [NUM_CHN-1:0]    sel_d, sel_q;
    logic                  sel_valid_d, sel_valid_q;
    logic [NUM_CHN-1:0]    buf_wr_d, buf_wr_q;
    logic [NUM_CHN-1:0]    buf_done_d, buf_done_q;
    logic [ADDR_WIDTH-1:0] waddr_d, waddr_q;
    logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
    logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;
    logic [CNT_WIDTH-1:0]  nwords_d, nwords_q;
    logic                  err_bad_d, err_bad_q;
    logic                  err_ovf_d, err_ovf_q;

    logic wr_ok, done_ok, bad_evt, ovf_evt;

    // Stage 1: decode the channel number one edge ahead of the write it qualifies
    always_comb begin
        sel_d = '0;
        for (int i = 0; i < NUM_CHN; i++)
            sel_d[i] = (int'(ext_buf_wchn) == i) && CHN_MASK[i];
        sel_valid_d = |sel_d;
    end

    // Stage 2: strobes, capture, counting and error flags use the selection from stage 1
    always_comb begin
        wr_ok   = ext_buf_wr && sel_valid_q;
        done_ok = seq_done && sel_valid_q;
        bad_evt = (ext_buf_wr || seq_done) && !sel_valid_q;
        ovf_evt = cnt_would_ovf(cnt_q, wr_ok);

        buf_wr_d   = sel_q & {NUM_CHN{ext_buf_wr}};
        buf_done_d = sel_q & {NUM_CHN{seq_done}};

        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (wr_ok) begin
            waddr_d = ext_buf_waddr;
            wdata_d = ext_buf_wdata;
        end

        cnt_d    = cnt_q;
        nwords_d = nwords_q;
        if (done_ok) begin
            // a write landing together with done still belongs to the finishing sequence
            nwords_d = cnt_sat_inc(cnt_q, ext_buf_wr);
            cnt_d    = '0;
        end else if (wr_ok) begin
            cnt_d = cnt_sat_inc(cnt_q, 1'b1);
        end

        err_bad_d = bad_evt || (err_bad_q && !err_clr);
        err_ovf_d = ovf_evt || (err_ovf_q && !err_clr);
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            buf_wr_q    <= '0;
            buf_done_q  <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            nwords_q    <= '0;
            err_bad_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            buf_wr_q    <= buf_wr_d;
            buf_done_q  <= buf_done_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            nwords_q    <= nwords_d;
            err_bad_q   <= err_bad_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign buf_wr      = buf_wr_q;
    assign buf_done    = buf_done_q;
    assign buf_waddr   = waddr_q;
    assign buf_wdata   = wdata_q;
    assign buf_nwords  = nwords_q;
    assign err_bad_chn = err_bad_q;
    assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_mcont_to_chnbuf_demux.sv
// Scoreboard bench for mcont_to_chnbuf_demux: channel 0 masked and a 3-bit counter so that
// masking and saturation are reachable from one instance.
module tb_mcont_to_chnbuf_demux;

    localparam int          NUM_CHN    = 16;
    localparam int          CHN_WIDTH  = 4;
    localparam int          ADDR_WIDTH = 7;
    localparam int          DATA_WIDTH = 64;
    localparam int          CNT_WIDTH  = 3;
    localparam logic [15:0] CHN_MASK   = 16'hfffe;
    localparam int          CNT_MAX    = 7;

    logic                  rst, clk;
    logic                  ext_buf_wr, seq_done, err_clr;
    logic [ADDR_WIDTH-1:0] ext_buf_waddr;
    logic [CHN_WIDTH-1:0]  ext_buf_wchn;
    logic [DATA_WIDTH-1:0] ext_buf_wdata;
    logic [NUM_CHN-1:0]    buf_wr, buf_done;
    logic [ADDR_WIDTH-1:0] buf_waddr;
    logic [DATA_WIDTH-1:0] buf_wdata;
    logic [CNT_WIDTH-1:0]  buf_nwords;
    logic                  err_bad_chn, err_ovf;

    mcont_to_chnbuf_demux #(
        .NUM_CHN(NUM_CHN), .CHN_WIDTH(CHN_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH), .CHN_MASK(CHN_MASK)
    ) dut (
        .rst(rst), .clk(clk), .ext_buf_wr(ext_buf_wr), .ext_buf_waddr(ext_buf_waddr),
        .ext_buf_wchn(ext_buf_wchn), .ext_buf_wdata(ext_buf_wdata), .seq_done(seq_done),
        .err_clr(err_clr), .buf_wr(buf_wr), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .buf_done(buf_done), .buf_nwords(buf_nwords), .err_bad_chn(err_bad_chn),
        .err_ovf(err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(negedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NUM_CHN-1:0]    oh;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [CNT_WIDTH-1:0]  nw;
        int                    cyc;
    } ev_t;

    ev_t wq[$];
    ev_t dq[$];

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Bench-side expectations
    int                    prev_chn;
    int                    cnt_m;
    logic                  exp_bad, exp_ovf;
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [CNT_WIDTH-1:0]  exp_nw;

    always @(posedge clk) begin : mon
        ev_t e;
        if (!rst) begin
            if (buf_wr != '0) begin
                if (wq.size() == 0) begin
                    chk("unexpected_buf_wr", 64'(buf_wr), 64'd0);
                end else begin
                    e = wq.pop_front();
                    chk("buf_wr_onehot", 64'(buf_wr), 64'(e.oh));
                    chk("buf_wr_latency", 64'(cyc), 64'(e.cyc));
                    chk("wr_addr", 64'(buf_waddr), 64'(e.addr));
                    chk("wr_data", buf_wdata, e.data);
                end
            end
            if (buf_done != '0) begin
                if (dq.size() == 0) begin
                    chk("unexpected_buf_done", 64'(buf_done), 64'd0);
                end else begin
                    e = dq.pop_front();
                    chk("buf_done_onehot", 64'(buf_done), 64'(e.oh));
                    chk("buf_done_latency", 64'(cyc), 64'(e.cyc));
                    chk("done_nwords", 64'(buf_nwords), 64'(e.nw));
                end
            end
        end
    end

    task automatic model_reset();
        prev_chn = -1;
        cnt_m    = 0;
        exp_bad  = 1'b0;
        exp_ovf  = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_nw   = '0;
    endtask

    // One cycle of stimulus; nxt is the channel presented now for next cycle's write/done.
    task automatic drive(input logic wr, input logic done, input logic clr,
                         input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d,
                         input int nxt);
        bit  ok;
        int  nw;
        ev_t e;
        @(posedge clk);
        chk("err_bad_chn", 64'(err_bad_chn), 64'(exp_bad));
        chk("err_ovf", 64'(err_ovf), 64'(exp_ovf));
        chk("buf_waddr_hold", 64'(buf_waddr), 64'(exp_addr));
        chk("buf_wdata_hold", buf_wdata, exp_data);
        chk("buf_nwords_hold", 64'(buf_nwords), 64'(exp_nw));
        ext_buf_wr    = wr;
        seq_done      = done;
        err_clr       = clr;
        ext_buf_waddr = a;
        ext_buf_wdata = d;
        ext_buf_wchn  = nxt[CHN_WIDTH-1:0];

        ok = (prev_chn >= 0) && (prev_chn < NUM_CHN) && CHN_MASK[prev_chn];
        if (clr) begin
            exp_bad = 1'b0;
            exp_ovf = 1'b0;
        end
        if ((wr || done) && !ok) exp_bad = 1'b1;
        if (ok) begin
            e.oh  = NUM_CHN'(1) << prev_chn;
            e.cyc = cyc + 1;
            e.addr = a;
            e.data = d;
            nw = cnt_m;
            if (wr) begin
                wq.push_back(e);
                exp_addr = a;
                exp_data = d;
                if (cnt_m == CNT_MAX) exp_ovf = 1'b1;
                else nw = cnt_m + 1;
            end
            if (done) begin
                e.nw = CNT_WIDTH'(nw);
                dq.push_back(e);
                exp_nw = CNT_WIDTH'(nw);
                cnt_m = 0;
            end else begin
                cnt_m = nw;
            end
        end
        prev_chn = nxt;
    endtask

    task automatic idle(input int nxt);
        drive(1'b0, 1'b0, 1'b0, '0, '0, nxt);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        ext_buf_wr = 1'b0; seq_done = 1'b0; err_clr = 1'b0;
        ext_buf_waddr = '0; ext_buf_wdata = '0; ext_buf_wchn = '0;
        model_reset();
        repeat (2) @(posedge clk);
        chk("rst_buf_wr", 64'(buf_wr), 64'd0);
        chk("rst_buf_done", 64'(buf_done), 64'd0);
        chk("rst_buf_waddr", 64'(buf_waddr), 64'd0);
        chk("rst_buf_wdata", buf_wdata, 64'd0);
        chk("rst_buf_nwords", 64'(buf_nwords), 64'd0);
        chk("rst_err_flags", {62'd0, err_bad_chn, err_ovf}, 64'd0);
        rst = 1'b0;

        // Channel 3: four writes, done on the last one
        idle(3);
        for (int i = 0; i < 4; i++)
            drive(1'b1, i == 3, 1'b0, ADDR_WIDTH'(i), 64'hA0 + 64'(i), 3);
        idle(0);

        // Masked channel 0: no strobes, capture holds, sticky error, then clear
        drive(1'b1, 1'b0, 1'b0, 7'd10, {$urandom, $urandom}, 0);
        drive(1'b1, 1'b0, 1'b0, 7'd11, {$urandom, $urandom}, 0);
        idle(0);
        drive(1'b0, 1'b0, 1'b1, '0, '0, 5);
        idle(5);

        // Channel 5: ten writes saturate the 3-bit counter
        for (int i = 0; i < 10; i++)
            drive(1'b1, 1'b0, 1'b0, ADDR_WIDTH'(20 + i), {$urandom, $urandom}, 5);
        drive(1'b0, 1'b1, 1'b0, '0, '0, 5);
        idle(5);
        drive(1'b0, 1'b0, 1'b1, '0, '0, 2);

        // Back-to-back sequences: channel 2 (three writes) then channel 9 (one write)
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 7'd40, {$urandom, $urandom}, 2);
        drive(1'b1, 1'b0, 1'b0, 7'd41, {$urandom, $urandom}, 2);
        drive(1'b1, 1'b1, 1'b0, 7'd42, {$urandom, $urandom}, 9);
        drive(1'b1, 1'b1, 1'b0, 7'd50, {$urandom, $urandom}, 4);
        idle(4);

        // Asynchronous reset in the middle of a channel-4 burst
        drive(1'b1, 1'b0, 1'b0, 7'd60, {$urandom, $urandom}, 4);
        drive(1'b1, 1'b0, 1'b0, 7'd61, {$urandom, $urandom}, 4);
        @(negedge clk);
        #2;
        rst = 1'b1;
        ext_buf_wr = 1'b0; seq_done = 1'b0; err_clr = 1'b0;
        #1;
        chk("async_rst_buf_wr", 64'(buf_wr), 64'd0);
        chk("async_rst_buf_waddr", 64'(buf_waddr), 64'd0);
        chk("async_rst_buf_wdata", buf_wdata, 64'd0);
        chk("async_rst_buf_nwords", 64'(buf_nwords), 64'd0);
        wq.delete();
        dq.delete();
        model_reset();
        @(posedge clk);
        rst = 1'b0;

        // Done with no writes on channel 1 after reset, then on channel 15
        idle(1);
        drive(1'b0, 1'b1, 1'b0, '0, '0, 15);
        drive(1'b0, 1'b1, 1'b0, '0, '0, 0);
        idle(0);
        idle(0);
        @(posedge clk);

        chk("wr_queue_drained", 64'(wq.size()), 64'd0);
        chk("done_queue_drained", 64'(dq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
